// File: rtl/slide_offset_ctrl.sv
// slide_offset_ctrl
//   Sequencer for vslideup/vslidedown column-offset generation. Accepts one
//   slide command (direction, shift amount, VL), walks it through
//   LOAD -> RUN (one beat per lane group) -> DONE, and drives the control
//   inputs of the column offset register. One command in flight; stall-aware.
// Ports
//   clk_i, rst_i          clock, synchronous active-high reset
//   start_i / ready_o     command handshake (accepted when both high)
//   slide_dir_i           0 = slide up, 1 = slide down
//   shift_amount_i, vl_i  slide offset and vector length, sampled at accept
//   stall_i               freezes RUN progress
//   shift_amount_o        latched shift amount
//   input_sel_o           00 NOP, 01 right shift, 10 left shift, 11 load
//   adder_input_sel_o     00 SA+i, 01 SA+VLANE_NUM-i, 11 idle
//   en_comp_o             valid-data compare enable
//   start_decrementor_o   advance write-enable decrementor
//   beat_idx_o            current beat in RUN, else 0
//   busy_o, done_o        ~ready_o, one-cycle completion pulse
module slide_offset_ctrl #(
  parameter int VREG_LOC_PER_LANE = 8,
  parameter int VLANE_NUM         = 8,
  localparam int SA_W   = $clog2(VREG_LOC_PER_LANE*4*8*VLANE_NUM),
  localparam int BEAT_W = $clog2(VREG_LOC_PER_LANE*4*8) + 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  output logic              ready_o,
  input  logic              slide_dir_i,
  input  logic [SA_W-1:0]   shift_amount_i,
  input  logic [SA_W:0]     vl_i,
  input  logic              stall_i,
  output logic [SA_W-1:0]   shift_amount_o,
  output logic [1:0]        input_sel_o,
  output logic [1:0]        adder_input_sel_o,
  output logic              en_comp_o,
  output logic              start_decrementor_o,
  output logic [BEAT_W-1:0] beat_idx_o,
  output logic              busy_o,
  output logic              done_o
);

  localparam int LG_LANES = $clog2(VLANE_NUM);
  // One bit of headroom over vl so the rounding add can never overflow.
  localparam int NB_W = SA_W + 2;
  localparam logic [NB_W-1:0] ROUND = NB_W'(VLANE_NUM - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t            r_state, w_next;
  logic              r_dir;
  logic [SA_W-1:0]   r_sa;
  logic [NB_W-1:0]   r_last;   // nbeats-1, index of the final beat
  logic [BEAT_W-1:0] r_beat;

  logic              w_accept;
  logic [NB_W-1:0]   w_nbeats;
  logic [NB_W-1:0]   w_beat_ext;
  logic              w_last_beat;

  assign w_accept    = (r_state == S_IDLE) && start_i;
  assign w_nbeats    = ({1'b0, vl_i} + ROUND) >> LG_LANES;
  assign w_beat_ext  = {{(NB_W-BEAT_W){1'b0}}, r_beat};
  assign w_last_beat = (w_beat_ext == r_last);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
      r_dir   <= 1'b0;
      r_sa    <= '0;
      r_last  <= '0;
      r_beat  <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_dir  <= slide_dir_i;
        r_sa   <= shift_amount_i;
        // vl==0 skips RUN entirely, so the wrapped value is never used.
        r_last <= w_nbeats - NB_W'(1);
      end
      if (r_state == S_LOAD)
        r_beat <= '0;
      else if (r_state == S_RUN && !stall_i)
        r_beat <= r_beat + BEAT_W'(1);
    end
  end

  always_comb begin
    w_next              = r_state;
    ready_o             = 1'b0;
    done_o              = 1'b0;
    input_sel_o         = 2'b00;
    adder_input_sel_o   = 2'b11;
    en_comp_o           = 1'b0;
    start_decrementor_o = 1'b0;
    beat_idx_o          = '0;
    unique case (r_state)
      S_IDLE: begin
        ready_o = 1'b1;
        if (start_i)
          w_next = (vl_i == '0) ? S_DONE : S_LOAD;
      end
      S_LOAD: begin
        input_sel_o       = 2'b11;
        adder_input_sel_o = r_dir ? 2'b01 : 2'b00;
        w_next            = S_RUN;
      end
      S_RUN: begin
        en_comp_o  = 1'b1;
        beat_idx_o = r_beat;
        // A stalled beat keeps compare enabled but issues no shift.
        if (!stall_i) begin
          input_sel_o         = r_dir ? 2'b10 : 2'b01;
          start_decrementor_o = 1'b1;
          if (w_last_beat)
            w_next = S_DONE;
        end
      end
      S_DONE: begin
        done_o = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign busy_o         = ~ready_o;
  assign shift_amount_o = r_sa;

endmodule

// File: tb/tb_slide_offset_ctrl.sv
module tb_slide_offset_ctrl;

  localparam int SA_W   = 11;
  localparam int BEAT_W = 9;

  logic              clk_i = 1'b0;
  logic              rst_i = 1'b1;
  logic              start_i = 1'b0;
  logic              ready_o;
  logic              slide_dir_i = 1'b0;
  logic [SA_W-1:0]   shift_amount_i = '0;
  logic [SA_W:0]     vl_i = '0;
  logic              stall_i = 1'b0;
  logic [SA_W-1:0]   shift_amount_o;
  logic [1:0]        input_sel_o;
  logic [1:0]        adder_input_sel_o;
  logic              en_comp_o;
  logic              start_decrementor_o;
  logic [BEAT_W-1:0] beat_idx_o;
  logic              busy_o;
  logic              done_o;

  slide_offset_ctrl dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .ready_o(ready_o),
    .slide_dir_i(slide_dir_i), .shift_amount_i(shift_amount_i), .vl_i(vl_i),
    .stall_i(stall_i), .shift_amount_o(shift_amount_o), .input_sel_o(input_sel_o),
    .adder_input_sel_o(adder_input_sel_o), .en_comp_o(en_comp_o),
    .start_decrementor_o(start_decrementor_o), .beat_idx_o(beat_idx_o),
    .busy_o(busy_o), .done_o(done_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic              ready;
    logic              busy;
    logic              done;
    logic [1:0]        isel;
    logic [1:0]        asel;
    logic              en;
    logic              sd;
    logic [BEAT_W-1:0] beat;
    logic [SA_W-1:0]   sa;
  } exp_t;

  exp_t            q[$];
  int              errors = 0;
  int              checks = 0;
  logic [SA_W-1:0] cur_sa = '0;

  function automatic exp_t e_idle(input logic [SA_W-1:0] sa);
    return '{ready:1'b1, busy:1'b0, done:1'b0, isel:2'b00, asel:2'b11,
             en:1'b0, sd:1'b0, beat:'0, sa:sa};
  endfunction

  function automatic exp_t e_load(input logic dir, input logic [SA_W-1:0] sa);
    return '{ready:1'b0, busy:1'b1, done:1'b0, isel:2'b11,
             asel:(dir ? 2'b01 : 2'b00), en:1'b0, sd:1'b0, beat:'0, sa:sa};
  endfunction

  function automatic exp_t e_run(input logic dir, input logic [SA_W-1:0] sa,
                                 input int beat, input logic stl);
    return '{ready:1'b0, busy:1'b1, done:1'b0,
             isel:(stl ? 2'b00 : (dir ? 2'b10 : 2'b01)), asel:2'b11,
             en:1'b1, sd:~stl, beat:BEAT_W'(beat), sa:sa};
  endfunction

  function automatic exp_t e_done(input logic [SA_W-1:0] sa);
    return '{ready:1'b0, busy:1'b1, done:1'b1, isel:2'b00, asel:2'b11,
             en:1'b0, sd:1'b0, beat:'0, sa:sa};
  endfunction

  // Drive one cycle of inputs, check the outputs of the current cycle
  // against the oldest queued expectation, then advance one clock.
  task automatic step(input logic st, input logic dir, input logic [SA_W-1:0] sa,
                      input logic [SA_W:0] vl, input logic stl, input logic rst,
                      input string tag);
    exp_t e, o;
    start_i = st; slide_dir_i = dir; shift_amount_i = sa; vl_i = vl;
    stall_i = stl; rst_i = rst;
    #1;
    e = q.pop_front();
    o = {ready_o, busy_o, done_o, input_sel_o, adder_input_sel_o, en_comp_o,
         start_decrementor_o, beat_idx_o, shift_amount_o};
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s: got rdy=%b bsy=%b dn=%b isel=%b asel=%b en=%b sd=%b beat=%0d sa=%0d want rdy=%b bsy=%b dn=%b isel=%b asel=%b en=%b sd=%b beat=%0d sa=%0d",
             tag, o.ready, o.busy, o.done, o.isel, o.asel, o.en, o.sd, o.beat, o.sa,
             e.ready, e.busy, e.done, e.isel, e.asel, e.en, e.sd, e.beat, e.sa);
    end
    @(posedge clk_i); #1;
  endtask

  // Full command from accept back to IDLE. With noise set, start_i is held
  // high with different operands in every busy cycle; it must be ignored.
  task automatic run_cmd(input logic dir, input logic [SA_W-1:0] sa,
                         input logic [SA_W:0] vl, input int stall_beat,
                         input int stall_len, input logic noise, input string tag);
    int nb;
    logic [SA_W-1:0] nsa;
    nb  = (int'(vl) + 7) / 8;
    nsa = ~sa;
    q.push_back(e_idle(cur_sa));
    step(1'b1, dir, sa, vl, 1'b0, 1'b0, $sformatf("%s accept", tag));
    cur_sa = sa;
    if (nb != 0) begin
      q.push_back(e_load(dir, sa));
      step(noise, ~dir, nsa, 12'd40, 1'b0, 1'b0, $sformatf("%s load", tag));
      for (int b = 0; b < nb; b++) begin
        if (b == stall_beat) begin
          for (int s = 0; s < stall_len; s++) begin
            q.push_back(e_run(dir, sa, b, 1'b1));
            step(noise, ~dir, nsa, 12'd40, 1'b1, 1'b0,
                 $sformatf("%s stall b%0d s%0d", tag, b, s));
          end
        end
        q.push_back(e_run(dir, sa, b, 1'b0));
        step(noise, ~dir, nsa, 12'd40, 1'b0, 1'b0, $sformatf("%s run b%0d", tag, b));
      end
    end
    q.push_back(e_done(sa));
    step(noise, ~dir, nsa, 12'd40, 1'b0, 1'b0, $sformatf("%s done", tag));
    q.push_back(e_idle(sa));
    step(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, $sformatf("%s idle", tag));
  endtask

  initial begin
    // Reset held for several cycles; outputs checked on three of them.
    rst_i = 1'b1;
    repeat (2) @(posedge clk_i);
    #1;
    for (int i = 0; i < 3; i++) begin
      q.push_back(e_idle('0));
      step(1'b0, 1'b0, '0, '0, 1'b0, 1'b1, $sformatf("reset c%0d", i));
    end

    run_cmd(1'b0, 11'd3,   12'd16, -1, 0, 1'b0, "up_sa3_vl16");
    run_cmd(1'b1, 11'd9,   12'd20, -1, 0, 1'b0, "down_sa9_vl20");
    run_cmd(1'b0, 11'd7,   12'd24,  1, 2, 1'b0, "stall_vl24");
    run_cmd(1'b0, 11'd2,   12'd0,  -1, 0, 1'b0, "vl0");
    run_cmd(1'b1, 11'd100, 12'd5,  -1, 0, 1'b1, "sa_ge_vl_noise");
    run_cmd(1'b1, 11'd1,   12'd33,  0, 1, 1'b1, "down_vl33_stall0");
    run_cmd(1'b0, 11'd2047, 12'd2048, 255, 1, 1'b0, "max_vl");

    // Reset during RUN beat 1 of a 64-element command.
    q.push_back(e_idle(cur_sa));
    step(1'b1, 1'b0, 11'd5, 12'd64, 1'b0, 1'b0, "abort accept");
    q.push_back(e_load(1'b0, 11'd5));
    step(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, "abort load");
    q.push_back(e_run(1'b0, 11'd5, 0, 1'b0));
    step(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, "abort run b0");
    q.push_back(e_run(1'b0, 11'd5, 1, 1'b0));
    step(1'b0, 1'b0, '0, '0, 1'b0, 1'b1, "abort run b1 rst");
    q.push_back(e_idle('0));
    step(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, "abort post-reset");
    q.push_back(e_idle('0));
    step(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, "abort no late done");
    cur_sa = '0;
    run_cmd(1'b1, 11'd4, 12'd8, -1, 0, 1'b0, "after_abort");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
